// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_pkg
// Purpose : Shared types and constants for the two-port RAM arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_RR    = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  localparam int NUM_REQ    = 2;
  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module  : rr_select
// Purpose : 2-way combinational grant selector (round-robin or fixed priority).
// Rev     : 1.0 - initial release
// ============================================================================
module rr_select
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  input  logic               fixed_prio,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = req;
    // Only contention needs a decision; a lone requester always wins.
    if (&req) begin
      gnt = '0;
      if (fixed_prio || !ptr) gnt[REQ_CPU] = 1'b1;
      else                    gnt[REQ_LOADER] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Purpose : Shares one single-port RAM between CPU and loader with RR + lock.
//           Define RAM_ARB_FIXED_PRIO_EN for fixed CPU priority (no pointer).
// Rev     : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     ram_load,
  output logic [ADDRESS_WIDTH-1:0] ram_address_in,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [NUM_REQ-1:0]  w_sel;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_ptr;
  logic                w_load;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam logic c_FIXED_PRIO = 1'b1;
  assign w_ptr = 1'b0;
`else
  localparam logic c_FIXED_PRIO = 1'b0;
  logic r_ptr;

  // Pointer names the requester preferred at the next contention.
  always_ff @(posedge clk) begin
    if (reset)                    r_ptr <= 1'b0;
    else if (w_gnt[REQ_CPU])      r_ptr <= 1'b1;
    else if (w_gnt[REQ_LOADER])   r_ptr <= 1'b0;
  end
  assign w_ptr = r_ptr;
`endif

  rr_select u_rr_select (
    .req        (req),
    .ptr        (w_ptr),
    .fixed_prio (c_FIXED_PRIO),
    .gnt        (w_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARB_RR;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_gnt & ~we;
    end
  end

  always_comb begin
    w_gnt       = '0;
    w_state_nxt = r_state;
    case (r_state)
      ARB_RR: begin
        w_gnt = w_sel;
        if (w_gnt[REQ_CPU] && lock[REQ_CPU])            w_state_nxt = ARB_LOCK0;
        else if (w_gnt[REQ_LOADER] && lock[REQ_LOADER]) w_state_nxt = ARB_LOCK1;
      end
      ARB_LOCK0: begin
        w_gnt[REQ_CPU] = req[REQ_CPU];
        if (!req[REQ_CPU] || !lock[REQ_CPU]) w_state_nxt = ARB_RR;
      end
      ARB_LOCK1: begin
        w_gnt[REQ_LOADER] = req[REQ_LOADER];
        if (!req[REQ_LOADER] || !lock[REQ_LOADER]) w_state_nxt = ARB_RR;
      end
      default: w_state_nxt = ARB_RR;
    endcase
  end

  always_comb begin
    w_load         = 1'b0;
    ram_address_in = '0;
    ram_data_in    = '0;
    if (w_gnt[REQ_CPU]) begin
      w_load         = we[REQ_CPU];
      ram_address_in = addr0;
      ram_data_in    = wdata0;
    end else if (w_gnt[REQ_LOADER]) begin
      w_load         = we[REQ_LOADER];
      ram_address_in = addr1;
      ram_data_in    = wdata1;
    end
  end

  // Writes are suppressed while reset is held, even though gnt stays live.
  assign ram_load = w_load & ~reset;
  assign gnt      = w_gnt;
  assign rvalid   = r_rvalid;
  assign rdata    = ram_data_out;

endmodule
`default_nettype wire
